seq_mult: RTL and testbench

SEQ_MULT -- requirements
Module: seq_mult

---
 rtl/seq_mult.sv | 181 ++++++++++++++++++
 tb/tb_seq_mult.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mult (with helper seq_mult_rca)
//  Purpose  : Sequential unsigned shift-add multiplier. One partial-product
//             step per clock; a W x W multiply takes W RUN cycles followed by
//             a single DONE cycle, during which a new start may be accepted.
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  seq_mult_rca : W-bit ripple-carry adder/subtractor used for the partial
//  product accumulation. When i_sub is high the second operand is inverted
//  and a carry-in is forced, giving i_x - i_y.
// ----------------------------------------------------------------------------
module seq_mult_rca #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic         i_cin,
    input  logic         i_sub,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    // Carry ripples LSB to MSB through a chain of full adders.
    always_comb begin
        logic w_c;
        logic w_yb;
        o_sum = '0;
        w_c   = i_cin | i_sub;
        for (int i = 0; i < W; i++) begin
            w_yb     = i_y[i] ^ i_sub;
            o_sum[i] = i_x[i] ^ w_yb ^ w_c;
            w_c      = (i_x[i] & w_yb) | (w_c & (i_x[i] ^ w_yb));
        end
        o_cout = w_c;
    end

endmodule

// ----------------------------------------------------------------------------
//  seq_mult : top level.
// ----------------------------------------------------------------------------
module seq_mult #(
    parameter  int S = 3,
    localparam int W = 2 ** S
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    // State encoding; the fourth code is unreachable and recovers to idle.
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Counter value of the final shift-add step (counter is S+1 bits so it
    // could represent W, but it stops at W-1 and never wraps).
    localparam logic [S:0] c_LAST_STEP = (S + 1)'(W - 1);

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;

    logic [W-1:0]   r_mcand;    // latched multiplicand
    logic [W-1:0]   r_acc_hi;   // upper half of the accumulator
    logic [W-1:0]   r_acc_lo;   // lower half: multiplier bits, replaced by product bits
    logic [S:0]     r_cnt;      // step counter
    logic [2*W-1:0] r_p;        // registered product

    logic           w_accept;   // a start is taken on this edge
    logic           w_last;     // current RUN step is the final one
    logic           w_add_en;   // multiplier LSB selects an add this step
    logic [W-1:0]   w_sum;
    logic           w_cout;
    logic           w_carry;
    logic [W-1:0]   w_hi_pre;
    logic [W-1:0]   w_hi_nxt;
    logic [W-1:0]   w_lo_nxt;

    assign w_accept = ((r_state == c_IDLE) || (r_state == c_DONE)) && start;
    assign w_last   = (r_cnt == c_LAST_STEP);
    assign w_add_en = r_acc_lo[0];

    // The adder always adds; the step logic below decides whether to use it.
    seq_mult_rca #(
        .W (W)
    ) u_rca (
        .i_x    (r_acc_hi),
        .i_y    (r_mcand),
        .i_cin  (1'b0),
        .i_sub  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // One shift-add step: conditional add into the high half, then shift the
    // 2W+1-bit {carry, hi, lo} right by one so the carry is never dropped.
    always_comb begin
        w_carry  = 1'b0;
        w_hi_pre = r_acc_hi;
        if (w_add_en) begin
            w_carry  = w_cout;
            w_hi_pre = w_sum;
        end
        w_hi_nxt = {w_carry, w_hi_pre[W-1:1]};
        w_lo_nxt = {w_hi_pre[0], r_acc_lo[W-1:1]};
    end

    // State register with asynchronous abort on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: W RUN cycles per operation, DONE lasts one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  w_state_nxt = start ? c_RUN : c_IDLE;
            c_RUN:   w_state_nxt = w_last ? c_DONE : c_RUN;
            c_DONE:  w_state_nxt = start ? c_RUN : c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Status outputs come straight from the state register, no input paths.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (r_state)
            c_IDLE:  ready = 1'b1;
            c_RUN:   busy  = 1'b1;
            c_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: ready = 1'b0;
        endcase
    end

    // Operand latch, accumulator stepping, counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
            r_p      <= '0;
        end else if (w_accept) begin
            r_mcand  <= a;
            r_acc_hi <= '0;
            r_acc_lo <= b;
            r_cnt    <= '0;
        end else if (r_state == c_RUN) begin
            r_acc_hi <= w_hi_nxt;
            r_acc_lo <= w_lo_nxt;
            if (w_last) begin
                // Capture the post-step value so the final step is included.
                r_p <= {w_hi_nxt, w_lo_nxt};
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign p = r_p;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_seq_mult
//  Purpose  : Self-checking bench for seq_mult (S=3, W=8): directed cases with
//             literal expectations plus a randomized sweep, all outputs
//             compared every cycle against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult;

    localparam int S              = 3;
    localparam int W              = 8;
    localparam int N_RAND_OPS     = 4000;
    localparam int RAND_CYCLE_CAP = 60000;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a     = '0;
    logic [W-1:0]   b     = '0;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    seq_mult #(.S(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    // Transaction model: an accepted multiply occupies W cycles, then the
    // product a*b appears together with a one-cycle done flag.
    int             m_left = 0;
    logic           m_done = 1'b0;
    logic [2*W-1:0] m_p    = '0;
    logic [2*W-1:0] m_prod = '0;
    int             m_ops  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_p    = '0;
            m_prod = '0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            m_done = (m_left == 0);
            if (m_left == 0) begin
                m_p   = m_prod;
                m_ops = m_ops + 1;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_prod = (2*W)'(a) * (2*W)'(b);
                m_left = W;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("ready", ready, (m_left == 0));
                chk("busy",  busy,  (m_left > 0));
                chk("done",  done,  m_done);
                chk("p",     p,     m_p);
            end
        end
    endtask

    function automatic logic [W-1:0] pick();
        int r;
        r = $urandom_range(7);
        if (r == 0) return '0;
        if (r == 1) return '1;
        return W'($urandom);
    endfunction

    // One operation with a single-cycle start; optionally stirs start/a/b
    // while the multiply is running.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic [2*W-1:0] exp, input bit noise, input string name);
        int cnt;
        int nbusy;
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb_;
        @(negedge clk);
        cnt   = 1;
        nbusy = busy ? 1 : 0;
        start = 1'b0;
        if (noise) begin
            a     = W'($urandom);
            b     = W'($urandom);
            start = 1'b1;
        end
        while (!done && cnt < W + 4) begin
            @(negedge clk);
            cnt++;
            if (busy) nbusy++;
            if (noise) begin
                a     = W'($urandom);
                b     = W'($urandom);
                start = (cnt <= W) ? 1'($urandom) : 1'b0;
            end
        end
        start = 1'b0;
        chk({name, "_latency"}, cnt, W + 1);
        chk({name, "_busy_cycles"}, nbusy, W);
        chk({name, "_p"}, p, exp);
        chk({name, "_model"}, m_p, exp);
    endtask

    initial begin
        int cnt;
        int ndone;
        int cycles;
        int target;

        fork
            compare_loop();
        join_none

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_ready", ready, 1);
        chk("rst_busy",  busy,  0);
        chk("rst_done",  done,  0);
        chk("rst_p",     p,     0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed products.
        run_op(8'd255, 8'd255, 16'hFE01, 1'b0, "ff_x_ff");
        run_op(8'd0,   8'hA5,  16'h0000, 1'b0, "zero_x_a5");
        run_op(8'd1,   8'hA5,  16'h00A5, 1'b0, "one_x_a5");
        run_op(8'h80,  8'd2,   16'h0100, 1'b0, "80_x_2");

        // Back-to-back with start held high.
        @(negedge clk);
        start = 1'b1;
        a     = 8'd3;
        b     = 8'd7;
        cnt   = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!done && cnt < W + 4);
        chk("b2b_latency1", cnt, W + 1);
        chk("b2b_p1", p, 16'd21);
        a = 8'd12;
        b = 8'd12;
        @(negedge clk);
        chk("b2b_no_idle", busy, 1);
        cnt = 1;
        while (!done && cnt < W + 4) begin
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        chk("b2b_latency2", cnt, W + 1);
        chk("b2b_p2", p, 16'd144);

        // Extra starts and operand churn during RUN.
        run_op(8'd37, 8'd91, 16'h0D27, 1'b1, "noisy_run");

        // Asynchronous abort at step 4.
        @(negedge clk);
        start = 1'b1;
        a     = 8'd200;
        b     = 8'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_busy",  busy,  0);
        chk("abort_done",  done,  0);
        chk("abort_p",     p,     0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (W + 3) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_op(8'd6, 8'd7, 16'd42, 1'b0, "after_abort");

        // Random sweep; the model checks every cycle.
        cycles = 0;
        target = m_ops + N_RAND_OPS;
        while (m_ops < target && cycles < RAND_CYCLE_CAP) begin
            @(negedge clk);
            cycles++;
            start = ($urandom_range(3) != 0);
            a     = pick();
            b     = pick();
        end
        start = 1'b0;
        chk("rand_ops_completed", (m_ops >= target), 1);
        repeat (W + 3) @(negedge clk);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
